// File: rtl/ddr_pkg.sv
// Shared HDR-DDR receive definitions: mode encodings, field lengths,
// CRC token constant and the parity helper.
package ddr_pkg;

  typedef enum logic [2:0] {
    MODE_PREAMBLE  = 3'd0,
    MODE_DATA      = 3'd1,
    MODE_PARITY    = 3'd2,
    MODE_CRC_TOKEN = 3'd3,
    MODE_CRC_VALUE = 3'd4
  } mode_e;

  localparam logic [3:0] LEN_PREAMBLE  = 4'd2;
  localparam logic [3:0] LEN_DATA      = 4'd8;
  localparam logic [3:0] LEN_PARITY    = 4'd2;
  localparam logic [3:0] LEN_CRC_TOKEN = 4'd4;
  localparam logic [3:0] LEN_CRC_VALUE = 4'd5;

  localparam logic [3:0] CRC_TOKEN = 4'b1100;

  // {P1, P0}: P1 over odd bits, P0 over even bits inverted, across both bytes.
  function automatic logic [1:0] ddr_parity(input logic [7:0] d1, input logic [7:0] d2);
    logic p1;
    logic p0;
    p1 = d1[7] ^ d1[5] ^ d1[3] ^ d1[1] ^ d2[7] ^ d2[5] ^ d2[3] ^ d2[1];
    p0 = d1[6] ^ d1[4] ^ d1[2] ^ d1[0] ^ d2[6] ^ d2[4] ^ d2[2] ^ d2[0] ^ 1'b1;
    return {p1, p0};
  endfunction

endpackage

// File: rtl/ddr_rx_deser.sv
// Edge-qualified MSB-first shift register with bit counter.
// o_last is asserted combinationally on the sample that completes a field
// of i_len bits; o_field then holds the complete field (LSB = current bit).
module ddr_rx_deser
  import ddr_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_edge,
  input  logic       i_sda,
  input  logic [3:0] i_len,
  output logic       o_last,
  output logic [7:0] o_field
);

  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;

  assign o_field = {shreg_q[6:0], i_sda};
  assign o_last  = i_edge && ({1'b0, cnt_q} == (i_len - 4'd1));

  // Next counter / shift state: clear wins, a completed field restarts at zero.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (i_clr) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (o_last) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (i_edge) begin
      cnt_d   = cnt_q + 3'd1;
      shreg_d = o_field;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/ddr_rx.sv
// HDR-DDR receive deserializer: field sequencing, byte capture, parity,
// CRC token and CRC value checks around ddr_rx_deser.
// Optional macro DDR_RX_CRC_CHECK_EN enables the CRC value comparison and
// drives the o_crc_* outputs; otherwise those outputs are tied low.
module ddr_rx
  import ddr_pkg::*;
(
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_ddrccc_rx_en,
  input  logic [2:0] i_ddrccc_rx_mode,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_sdahnd_rx_sda,
  input  logic [4:0] i_crc_value,
  output logic       o_ddrccc_rx_mode_done,
  output logic [1:0] o_ddrccc_preamble,
  output logic [7:0] o_regfcrc_rx_data_out,
  output logic       o_regf_wr_en,
  output logic       o_ddrccc_error,
  output logic       o_crc_en,
  output logic       o_crc_data_valid,
  output logic       o_crc_last_byte,
  output logic [7:0] o_crc_parallel_data
);

  mode_e      mode;
  mode_e      mode_prev_q;
  logic       mode_chg;
  logic       active;
  logic [3:0] len;
  logic       clr;
  logic       samp;
  logic       last;
  logic [7:0] field;
  logic       byte_done;

  logic       done_q, done_d;
  logic       wr_q, wr_d;
  logic       err_q, err_d;
  logic       tog_q, tog_d;
  logic [1:0] pre_q, pre_d;
  logic [7:0] data_q, data_d;
  logic [7:0] d1_q, d1_d;
  logic [7:0] d2_q, d2_d;

  assign mode     = mode_e'(i_ddrccc_rx_mode);
  assign mode_chg = (mode != mode_prev_q);
  assign clr      = !i_ddrccc_rx_en || mode_chg;
  assign samp     = (i_sclgen_scl_pos_edge || i_sclgen_scl_neg_edge) &&
                    i_ddrccc_rx_en && active && !mode_chg;
  assign byte_done = last && (mode == MODE_DATA);

  // Field length per mode; encodings 5-7 are idle.
  always_comb begin
    active = 1'b1;
    len    = 4'd0;
    case (mode)
      MODE_PREAMBLE:  len = LEN_PREAMBLE;
      MODE_DATA:      len = LEN_DATA;
      MODE_PARITY:    len = LEN_PARITY;
      MODE_CRC_TOKEN: len = LEN_CRC_TOKEN;
      MODE_CRC_VALUE: len = LEN_CRC_VALUE;
      default:        active = 1'b0;
    endcase
  end

  ddr_rx_deser u_deser (
    .i_clk   (i_sys_clk),
    .i_rst   (i_sys_rst),
    .i_clr   (clr),
    .i_edge  (samp),
    .i_sda   (i_sdahnd_rx_sda),
    .i_len   (len),
    .o_last  (last),
    .o_field (field)
  );

  // Field completion: latch results, run checks, pulse strobes.
  always_comb begin
    done_d = 1'b0;
    wr_d   = 1'b0;
    err_d  = err_q;
    tog_d  = tog_q;
    pre_d  = pre_q;
    data_d = data_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    if (!i_ddrccc_rx_en) begin
      err_d = 1'b0;
      tog_d = 1'b0;
    end else if (last) begin
      done_d = 1'b1;
      case (mode)
        MODE_PREAMBLE: pre_d = field[1:0];
        MODE_DATA: begin
          data_d = field;
          wr_d   = 1'b1;
          tog_d  = !tog_q;
          if (tog_q) d2_d = field;
          else       d1_d = field;
        end
        MODE_PARITY: begin
          if (field[1:0] != ddr_parity(d1_q, d2_q)) err_d = 1'b1;
          tog_d = 1'b0;
        end
        MODE_CRC_TOKEN: if (field[3:0] != CRC_TOKEN) err_d = 1'b1;
`ifdef DDR_RX_CRC_CHECK_EN
        MODE_CRC_VALUE: if (field[4:0] != i_crc_value) err_d = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Main state register.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      mode_prev_q <= MODE_PREAMBLE;
      done_q      <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      tog_q       <= 1'b0;
      pre_q       <= '0;
      data_q      <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
    end else begin
      mode_prev_q <= mode;
      done_q      <= done_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      tog_q       <= tog_d;
      pre_q       <= pre_d;
      data_q      <= data_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
    end
  end

  assign o_ddrccc_rx_mode_done = done_q;
  assign o_regf_wr_en          = wr_q;
  assign o_ddrccc_error        = err_q;
  assign o_ddrccc_preamble     = pre_q;
  assign o_regfcrc_rx_data_out = data_q;

`ifdef DDR_RX_CRC_CHECK_EN
  logic       crc_en_q, crc_en_d;
  logic       crc_dv_q, crc_dv_d;
  logic       crc_lb_q, crc_lb_d;
  logic [7:0] crc_pd_q, crc_pd_d;

  // CRC engine interface: enable by mode, byte strobe on each data byte.
  always_comb begin
    crc_en_d = i_ddrccc_rx_en && (mode == MODE_DATA || mode == MODE_CRC_TOKEN ||
                                  mode == MODE_CRC_VALUE);
    crc_lb_d = i_ddrccc_rx_en && (mode == MODE_CRC_TOKEN);
    crc_dv_d = i_ddrccc_rx_en && byte_done;
    crc_pd_d = crc_pd_q;
    if (crc_dv_d) crc_pd_d = field;
  end

  // CRC interface register.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      crc_en_q <= 1'b0;
      crc_dv_q <= 1'b0;
      crc_lb_q <= 1'b0;
      crc_pd_q <= '0;
    end else begin
      crc_en_q <= crc_en_d;
      crc_dv_q <= crc_dv_d;
      crc_lb_q <= crc_lb_d;
      crc_pd_q <= crc_pd_d;
    end
  end

  assign o_crc_en            = crc_en_q;
  assign o_crc_data_valid    = crc_dv_q;
  assign o_crc_last_byte     = crc_lb_q;
  assign o_crc_parallel_data = crc_pd_q;
`else
  logic unused_crc;
  assign unused_crc          = ^{i_crc_value, byte_done};
  assign o_crc_en            = 1'b0;
  assign o_crc_data_valid    = 1'b0;
  assign o_crc_last_byte     = 1'b0;
  assign o_crc_parallel_data = 8'h00;
`endif

endmodule

// File: tb/tb_ddr_rx.sv
// Directed bench for ddr_rx: inputs change on the falling clock edge,
// outputs are checked there too, half a cycle after the capturing edge.
module tb_ddr_rx;
  import ddr_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, pos, neg, sda;
  logic [2:0] mode;
  logic [4:0] crc_val;
  logic       done, wr, err, crc_en, crc_dv, crc_lb;
  logic [1:0] pre;
  logic [7:0] dout, crc_pd;
  logic       alt = 1'b0;
  int         checks = 0;
  int         errors = 0;

`ifdef DDR_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  ddr_rx dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_ddrccc_rx_en        (en),
    .i_ddrccc_rx_mode      (mode),
    .i_sclgen_scl_pos_edge (pos),
    .i_sclgen_scl_neg_edge (neg),
    .i_sdahnd_rx_sda       (sda),
    .i_crc_value           (crc_val),
    .o_ddrccc_rx_mode_done (done),
    .o_ddrccc_preamble     (pre),
    .o_regfcrc_rx_data_out (dout),
    .o_regf_wr_en          (wr),
    .o_ddrccc_error        (err),
    .o_crc_en              (crc_en),
    .o_crc_data_valid      (crc_dv),
    .o_crc_last_byte       (crc_lb),
    .o_crc_parallel_data   (crc_pd)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send n bits of v MSB first, one edge per cycle, alternating pos/neg.
  task automatic send(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sda = v[i];
      pos = alt;
      neg = !alt;
      alt = !alt;
      @(negedge clk);
    end
    pos = 1'b0;
    neg = 1'b0;
  endtask

  task automatic set_mode(input logic [2:0] m);
    mode = m;
    @(negedge clk);
  endtask

  task automatic en_cycle();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pos = 1'b0; neg = 1'b0; sda = 1'b0;
    mode = 3'd0; crc_val = 5'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", {7'd0, done}, 8'h00);
    chk("rst_data", dout, 8'h00);
    chk("rst_flags", {2'b0, pre, wr, err, crc_en, crc_dv}, 8'h00);

    // Single byte A5
    en = 1'b1;
    set_mode(MODE_DATA);
    send(8'hA5, 8);
    chk("a5_data", dout, 8'hA5);
    chk("a5_strobes", {6'd0, done, wr}, 8'h03);
    chk("a5_crc_dv", {7'd0, crc_dv}, {7'd0, CRC_ON});
    chk("a5_crc_pd", crc_pd, CRC_ON ? 8'hA5 : 8'h00);
    chk("a5_crc_en", {7'd0, crc_en}, {7'd0, CRC_ON});
    @(negedge clk);
    chk("a5_pulse_end", {5'd0, done, wr, crc_dv}, 8'h00);

    // 12,34 with good parity: P1=0, P0=(1^0)^1=0
    en_cycle();
    set_mode(MODE_DATA);
    send(8'h12, 8);
    send(8'h34, 8);
    chk("d2_data", dout, 8'h34);
    set_mode(MODE_PARITY);
    send(8'h00, 2);
    chk("par_ok", {6'd0, done, err}, 8'h02);
    // Repeat with bad parity 2'b10
    set_mode(MODE_DATA);
    send(8'h12, 8);
    send(8'h34, 8);
    set_mode(MODE_PARITY);
    send(8'h02, 2);
    chk("par_bad", {6'd0, done, err}, 8'h03);
    set_mode(MODE_DATA);
    repeat (3) @(negedge clk);
    chk("err_sticky", {7'd0, err}, 8'h01);
    en = 1'b0;
    @(negedge clk);
    chk("en_low_err", {7'd0, err}, 8'h00);
    chk("en_low_hold", dout, 8'h34);
    en = 1'b1;

    // CRC token
    set_mode(MODE_CRC_TOKEN);
    @(negedge clk);
    chk("tok_lb", {6'd0, crc_lb, crc_en}, CRC_ON ? 8'h03 : 8'h00);
    send(8'h0C, 4);
    chk("tok_ok", {6'd0, done, err}, 8'h02);
    send(8'h08, 4);
    chk("tok_bad", {6'd0, done, err}, 8'h03);
    en_cycle();

    // CRC value
    set_mode(MODE_CRC_VALUE);
    crc_val = 5'h15;
    send(8'h15, 5);
    chk("crcv_ok", {6'd0, done, err}, 8'h02);
    crc_val = 5'h14;
    send(8'h15, 5);
    chk("crcv_bad", {6'd0, done, err}, {6'd0, 1'b1, CRC_ON});
    chk("crcv_en", {7'd0, crc_en}, {7'd0, CRC_ON});
    en_cycle();

    // Abort DATA after 3 bits, then preamble 1,0
    set_mode(MODE_DATA);
    send(8'h05, 3);
    chk("abort_nodone", {7'd0, done}, 8'h00);
    mode = MODE_PREAMBLE;
    @(negedge clk);
    chk("abort_chg", {6'd0, done, wr}, 8'h00);
    send(8'h02, 2);
    chk("pre_val", {6'd0, pre}, 8'h02);
    chk("pre_done", {6'd0, done, wr}, 8'h02);
    chk("pre_data_hold", dout, 8'h34);

    // Reset mid-field
    set_mode(MODE_DATA);
    send(8'h0F, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_data", dout, 8'h00);
    chk("mrst_flags", {2'b0, pre, done, wr, err, crc_dv}, 8'h00);
    @(negedge clk);
    send(8'h5C, 8);
    chk("post_rst_data", dout, 8'h5C);
    chk("post_rst_done", {6'd0, done, wr}, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
